// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL reset/lock sequencer that holds sys_rst_n low until the PLL is stably locked.
//   refclk    - free-running reference clock (only clock)
//   rst_n     - asynchronous active-low reset
//   locked    - PLL lock indication (asynchronous, synchronized internally)
//   lost_clr  - single-cycle pulse clearing lock_lost
//   pll_rst   - active-high PLL reset, high while in PLL_RST
//   sys_rst_n - active-low reset for PLL-clocked logic, high only in RUN
//   ready     - high only in RUN
//   lock_lost - sticky flag set when lock drops in RUN
//   retry_cnt - saturating count of lock timeouts plus lock losses
module pll_lock_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       lost_clr,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_cnt
);
  localparam int MAX_AB = PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAXP = MAX_AB > LOCK_STABLE_CYCLES ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW = MAXP > 1 ? $clog2(MAXP) : 1;
  typedef enum logic [1:0] {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sync1_q, locked_s_q;
  logic pll_rst_q, run_q, lock_lost_q, lock_lost_d;
  logic [7:0] retry_q, retry_d;
  logic timeout, lost;
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    lost = 1'b0;
    case (state_q)
      S_PLL_RST:   if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (locked_s_q) state_d = S_STABLE;
                   else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                     state_d = S_PLL_RST;
                     timeout = 1'b1;
                   end
      S_STABLE:    if (!locked_s_q) state_d = S_WAIT_LOCK;
                   else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) state_d = S_RUN;
      S_RUN:       if (!locked_s_q) begin
                     state_d = S_PLL_RST;
                     lost = 1'b1;
                   end
      default:     state_d = S_PLL_RST;
    endcase
    // Every state entry restarts the count; RUN holds it so it never wraps.
    cnt_d = state_d != state_q ? '0 : state_q == S_RUN ? cnt_q : cnt_q + 1'b1;
    retry_d = (timeout | lost) && retry_q != 8'hFF ? retry_q + 8'd1 : retry_q;
    // A new loss wins over a simultaneous clear.
    lock_lost_d = lost | (lock_lost_q & ~lost_clr);
  end
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      run_q       <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= 8'd0;
    end else begin
      sync1_q     <= locked;
      locked_s_q  <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= state_d == S_PLL_RST;
      run_q       <= state_d == S_RUN;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end
  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = run_q;
  assign ready     = run_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;
endmodule
